// File: rtl/bus_arbiter.sv
// bus_arbiter: two-requester (fetch / load-store) arbiter onto one system bus.
// Each requester owns a one-deep pending slot; a five-state FSM issues the
// winner downstream, waits out the slave, and returns data/response to it.
// A watchdog in WAIT turns a hung slave into an ERROR completion.
// Optional feature macro: BUS_ARB_ROUND_ROBIN_EN (round-robin on contention;
// default build is fixed priority with load/store beating fetch).
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_start,
  input  logic [31:0] if_address,
  input  logic        if_write,
  input  logic [31:0] if_write_data,
  output logic        if_ready,
  output logic [1:0]  if_response,
  output logic [31:0] if_read_data,
  input  logic        ls_start,
  input  logic [31:0] ls_address,
  input  logic        ls_write,
  input  logic [31:0] ls_write_data,
  output logic        ls_ready,
  output logic [1:0]  ls_response,
  output logic [31:0] ls_read_data,
  output logic        bus_start,
  output logic [31:0] bus_address,
  output logic        bus_write,
  output logic [31:0] bus_write_data,
  input  logic        bus_ready,
  input  logic [1:0]  bus_response,
  input  logic [31:0] bus_read_data
);

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, DONE} state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        if_vld_q, ls_vld_q;
  logic [31:0] if_addr_q, ls_addr_q, if_wd_q, ls_wd_q;
  logic        if_wr_q, ls_wr_q;
  logic        gnt_ls_q;            // 1 = load/store owns the current transaction
  logic [31:0] bus_addr_q, bus_wd_q, rdata_q;
  logic        bus_wr_q;
  logic [1:0]  resp_q;
  logic [15:0] cnt_q;
  logic [1:0]  if_resp_q, ls_resp_q;
  logic [31:0] if_rdata_q, ls_rdata_q;
  logic        pick_ls, go, wait_end;

  assign if_ready       = ~if_vld_q;
  assign ls_ready       = ~ls_vld_q;
  assign if_response    = if_resp_q;
  assign ls_response    = ls_resp_q;
  assign if_read_data   = if_rdata_q;
  assign ls_read_data   = ls_rdata_q;
  assign bus_address    = bus_addr_q;
  assign bus_write      = bus_wr_q;
  assign bus_write_data = bus_wd_q;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic last_ls_q;                  // 0 = fetch granted last
  // On contention the requester that was not granted last wins.
  assign pick_ls = ls_vld_q & (~if_vld_q | ~last_ls_q);

  // Remember who was issued most recently.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                last_ls_q <= 1'b0;
    else if (state_q == ISSUE) last_ls_q <= gnt_ls_q;
  end
`else
  // Fixed priority: load/store beats fetch.
  assign pick_ls = ls_vld_q;
`endif

  assign go       = (if_vld_q | ls_vld_q) & bus_ready;
  assign wait_end = bus_ready | (cnt_q == TMO_LAST);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a stray bus_ready in IDLE only matters with a slot pending.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = ISSUE;
      ISSUE:   state_d = SETTLE;
      SETTLE:  state_d = WAIT;
      WAIT:    if (wait_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: the request pulse is purely state-driven so reset kills it at once.
  always_comb begin
    bus_start = 1'b0;
    if (state_q == ISSUE) bus_start = 1'b1;
  end

  // Pending slots: load on an accepted start, free on the owner's DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_vld_q <= 1'b0; if_addr_q <= '0; if_wr_q <= 1'b0; if_wd_q <= '0;
      ls_vld_q <= 1'b0; ls_addr_q <= '0; ls_wr_q <= 1'b0; ls_wd_q <= '0;
    end else begin
      if (if_start && !if_vld_q) begin
        if_vld_q <= 1'b1; if_addr_q <= if_address; if_wr_q <= if_write; if_wd_q <= if_write_data;
      end else if (state_q == DONE && !gnt_ls_q) begin
        if_vld_q <= 1'b0;
      end
      if (ls_start && !ls_vld_q) begin
        ls_vld_q <= 1'b1; ls_addr_q <= ls_address; ls_wr_q <= ls_write; ls_wd_q <= ls_write_data;
      end else if (state_q == DONE && gnt_ls_q) begin
        ls_vld_q <= 1'b0;
      end
    end
  end

  // Datapath: grant capture, watchdog, completion latch and return to the owner.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt_ls_q   <= 1'b0;
      bus_addr_q <= '0; bus_wr_q <= 1'b0; bus_wd_q <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0; resp_q <= '0;
      if_rdata_q <= '0; if_resp_q <= '0;
      ls_rdata_q <= '0; ls_resp_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (go) begin
          gnt_ls_q   <= pick_ls;
          bus_addr_q <= pick_ls ? ls_addr_q : if_addr_q;
          bus_wr_q   <= pick_ls ? ls_wr_q   : if_wr_q;
          bus_wd_q   <= pick_ls ? ls_wd_q   : if_wd_q;
        end
        SETTLE: cnt_q <= '0;
        WAIT: begin
          if (bus_ready) begin
            rdata_q <= bus_read_data;
            resp_q  <= {1'b0, |bus_response};
          end else begin
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q == TMO_LAST) begin
              rdata_q <= '0;
              resp_q  <= 2'd1;
            end
          end
        end
        DONE: begin
          if (gnt_ls_q) begin
            ls_rdata_q <= rdata_q; ls_resp_q <= resp_q;
          end else begin
            if_rdata_q <= rdata_q; if_resp_q <= resp_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (TIMEOUT_CYCLES = 4).
// Expectations follow the configured arbitration mode via BUS_ARB_ROUND_ROBIN_EN.
module tb_bus_arbiter;
  logic        clock = 1'b0, reset = 1'b0;
  logic        if_start = 0, if_write = 0, ls_start = 0, ls_write = 0;
  logic [31:0] if_address = 0, if_write_data = 0, ls_address = 0, ls_write_data = 0;
  logic        if_ready, ls_ready, bus_start, bus_write;
  logic [1:0]  if_response, ls_response;
  logic [31:0] if_read_data, ls_read_data, bus_address, bus_write_data;
  logic        bus_ready = 1'b1;
  logic [1:0]  bus_response = 2'd0;
  logic [31:0] bus_read_data = 32'd0;

  int n_vec = 0, n_err = 0, n_start = 0;

  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .if_start(if_start), .if_address(if_address), .if_write(if_write),
    .if_write_data(if_write_data), .if_ready(if_ready), .if_response(if_response),
    .if_read_data(if_read_data),
    .ls_start(ls_start), .ls_address(ls_address), .ls_write(ls_write),
    .ls_write_data(ls_write_data), .ls_ready(ls_ready), .ls_response(ls_response),
    .ls_read_data(ls_read_data),
    .bus_start(bus_start), .bus_address(bus_address), .bus_write(bus_write),
    .bus_write_data(bus_write_data), .bus_ready(bus_ready),
    .bus_response(bus_response), .bus_read_data(bus_read_data)
  );

  always #5 clock = ~clock;

  // Count downstream request pulses.
  always @(posedge clock) if (bus_start === 1'b1) n_start <= n_start + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic req_if(input logic [31:0] a, input logic w, input logic [31:0] d);
    if_start = 1; if_address = a; if_write = w; if_write_data = d;
    tick(); if_start = 0;
  endtask

  task automatic req_ls(input logic [31:0] a, input logic w, input logic [31:0] d);
    ls_start = 1; ls_address = a; ls_write = w; ls_write_data = d;
    tick(); ls_start = 0;
  endtask

  task automatic wait_issue(input string tag);
    int k = 0;
    while (bus_start !== 1'b1 && k < 20) begin tick(); k++; end
    chk({tag, "_issue"}, 32'(bus_start), 32'd1);
  endtask

  // Slave: accept the issue, stall, then complete; returns in the DONE cycle.
  task automatic slave(input string tag, input logic [31:0] ea, input logic ew,
                       input logic [31:0] ewd, input logic [31:0] rd,
                       input logic [1:0] rsp, input int waits);
    wait_issue(tag);
    chk({tag, "_addr"}, bus_address, ea);
    chk({tag, "_wr"}, 32'(bus_write), 32'(ew));
    chk({tag, "_wd"}, bus_write_data, ewd);
    bus_ready = 0;
    repeat (waits + 2) begin tick(); chk({tag, "_onepulse"}, 32'(bus_start), 32'd0); end
    bus_ready = 1; bus_read_data = rd; bus_response = rsp;
    tick();
    bus_read_data = 32'd0; bus_response = 2'd0;
  endtask

  initial begin
    int s, k;
    // Reset state
    repeat (2) @(posedge clock); #1;
    chk("rst_bus_start", 32'(bus_start), 32'd0);
    chk("rst_bus_addr", bus_address, 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd1);
    chk("rst_ls_ready", 32'(ls_ready), 32'd1);
    chk("rst_if_resp", 32'(if_response), 32'd0);
    chk("rst_ls_rdata", ls_read_data, 32'd0);
    reset = 1; tick();

    // Contention pair 1: ls wins in both modes from reset
    if_start = 1; if_address = 32'h0; if_write = 0; if_write_data = 0;
    ls_start = 1; ls_address = 32'h40; ls_write = 1; ls_write_data = 32'h12345678;
    tick(); if_start = 0; ls_start = 0;
    chk("p1_if_busy", 32'(if_ready), 32'd0);
    chk("p1_ls_busy", 32'(ls_ready), 32'd0);
    slave("p1a", 32'h40, 1'b1, 32'h12345678, 32'h0, 2'd0, 1);
    chk("p1a_done_notready", 32'(ls_ready), 32'd0);
    tick();
    chk("p1a_ls_ready", 32'(ls_ready), 32'd1);
    chk("p1a_ls_resp", 32'(ls_response), 32'd0);
    chk("p1a_if_held", 32'(if_ready), 32'd0);
    chk("p1a_if_rdata_held", if_read_data, 32'd0);
    slave("p1b", 32'h0, 1'b0, 32'h0, 32'hCAFE0001, 2'd0, 0);
    tick();
    chk("p1b_if_ready", 32'(if_ready), 32'd1);
    chk("p1b_if_rdata", if_read_data, 32'hCAFE0001);

    // Slave error is forwarded as ERROR (also makes ls the last grantee)
    req_ls(32'h80, 1'b0, 32'h0);
    slave("err", 32'h80, 1'b0, 32'h0, 32'h55AA55AA, 2'd2, 2);
    tick();
    chk("err_ls_resp", 32'(ls_response), 32'd1);
    chk("err_ls_rdata", ls_read_data, 32'h55AA55AA);
    chk("err_if_untouched", if_read_data, 32'hCAFE0001);

    // Contention pair 2: RR grants fetch, fixed priority grants ls
    if_start = 1; if_address = 32'h8; if_write = 0;
    ls_start = 1; ls_address = 32'h44; ls_write = 0;
    tick(); if_start = 0; ls_start = 0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    slave("p2a", 32'h8, 1'b0, 32'h0, 32'h11111111, 2'd0, 0);
    tick();
    slave("p2b", 32'h44, 1'b0, 32'h0, 32'h22222222, 2'd0, 0);
`else
    slave("p2a", 32'h44, 1'b0, 32'h0, 32'h22222222, 2'd0, 0);
    tick();
    slave("p2b", 32'h8, 1'b0, 32'h0, 32'h11111111, 2'd0, 0);
`endif
    tick();
    chk("p2_if_rdata", if_read_data, 32'h11111111);
    chk("p2_ls_rdata", ls_read_data, 32'h22222222);
    chk("p2_ls_resp", 32'(ls_response), 32'd0);

    // Single fetch, 3 wait cycles (the last one lands exactly on the watchdog limit)
    s = n_start;
    req_if(32'h100, 1'b0, 32'h0);
    slave("single", 32'h100, 1'b0, 32'h0, 32'hDEADBEEF, 2'd0, 3);
    chk("single_done_notready", 32'(if_ready), 32'd0);
    tick();
    chk("single_if_ready", 32'(if_ready), 32'd1);
    chk("single_if_rdata", if_read_data, 32'hDEADBEEF);
    chk("single_if_resp", 32'(if_response), 32'd0);
    chk("single_pulses", 32'(n_start - s), 32'd1);

    // Start while busy is ignored
    s = n_start;
    req_if(32'h200, 1'b0, 32'h0);
    if_start = 1; if_address = 32'h300;
    tick(); if_start = 0;
    slave("busy", 32'h200, 1'b0, 32'h0, 32'h0BADF00D, 2'd0, 1);
    tick();
    chk("busy_if_rdata", if_read_data, 32'h0BADF00D);
    repeat (4) tick();
    chk("busy_pulses", 32'(n_start - s), 32'd1);
    chk("busy_if_ready", 32'(if_ready), 32'd1);

    // Timeout: slave never answers
    req_ls(32'h300, 1'b1, 32'hA5A5A5A5);
    wait_issue("tmo");
    bus_ready = 0;
    k = 0;
    while (ls_ready !== 1'b1 && k < 20) begin tick(); k++; end
    chk("tmo_latency", 32'(k), 32'd7);
    chk("tmo_ls_resp", 32'(ls_response), 32'd1);
    chk("tmo_ls_rdata", ls_read_data, 32'd0);
    s = n_start;
    bus_ready = 1; bus_read_data = 32'h77777777;
    repeat (3) tick();
    chk("late_no_start", 32'(n_start - s), 32'd0);
    chk("late_ls_rdata", ls_read_data, 32'd0);
    chk("late_ls_ready", 32'(ls_ready), 32'd1);
    chk("late_if_rdata", if_read_data, 32'h0BADF00D);
    bus_read_data = 32'd0;

    // Reset in WAIT
    req_if(32'h400, 1'b0, 32'h0);
    wait_issue("rstw");
    bus_ready = 0;
    repeat (3) tick();
    reset = 0; #1;
    chk("rstw_bus_start", 32'(bus_start), 32'd0);
    chk("rstw_if_ready", 32'(if_ready), 32'd1);
    chk("rstw_ls_ready", 32'(ls_ready), 32'd1);
    chk("rstw_if_rdata", if_read_data, 32'd0);
    chk("rstw_ls_resp", 32'(ls_response), 32'd0);
    chk("rstw_bus_addr", bus_address, 32'd0);
    @(posedge clock); #1;
    reset = 1;
    bus_ready = 1; bus_read_data = 32'h99999999;
    s = n_start;
    repeat (4) tick();
    chk("rstw_no_start", 32'(n_start - s), 32'd0);
    chk("rstw_no_complete", if_read_data, 32'd0);
    chk("rstw_if_ready_after", 32'(if_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter sharing the core's single system bus between the instruction-fetch path and the load/store path of the RV32E control unit. Each requester sees the same start/ready/response handshake as the bus itself. The arbiter queues one transaction per requester, chooses between them, drives the downstream bus, and returns read data and response to the originator. A watchdog converts a hung slave into an error response.

## Interface
- TIMEOUT_CYCLES, 256: WAIT-state cycles before a forced ERROR completion; legal range 2..65535.
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- if_start / ls_start  in  1  one-cycle request pulse; honoured only while the matching *_ready is high.
- if_address / ls_address  in  32  byte address, captured with start.
- if_write / ls_write  in  1  1 = write, 0 = read; captured with start. if_write is carried like any other.
- if_write_data / ls_write_data  in  32  store data, captured with start.
- if_ready / ls_ready  out  1  high = no transaction pending or in flight for that requester.
- if_response / ls_response  out  2  0 = OKAY, 1 = ERROR; valid while *_ready is high, held until the next completion.
- if_read_data / ls_read_data  out  32  read result; held until the next completion.
- bus_start  out  1  one-cycle downstream request pulse.
- bus_address  out  32  downstream address, stable from bus_start until completion.
- bus_write  out  1  downstream write select.
- bus_write_data  out  32  downstream store data.
- bus_ready  in  1  slave idle/complete. Slave drops it the cycle after sampling bus_start.
- bus_response  in  2  slave response; any nonzero value is forwarded as ERROR (1).
- bus_read_data  in  32  slave read data, valid with bus_ready high after a transaction.

## Operation
- Per-requester pending slot: {valid, address, write, write_data}. It loads on start && ready. Loading drops *_ready on the next edge, and *_ready stays low until completion.
- start while *_ready is low: ignored, with no effect on state.
- FSM states: IDLE, ISSUE, SETTLE, WAIT, DONE.
  - IDLE: if any slot is valid and bus_ready=1, select a winner, copy its slot onto the bus_* signals, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: bus_start=1 for exactly this cycle, then go to SETTLE.
  - SETTLE: ignore bus_ready for this one cycle, covering the slave's registered ready, then go to WAIT. Clear the timeout counter.
  - WAIT: if bus_ready=1, latch bus_read_data and the mapped response, then go to DONE. Else increment the counter; when it reaches TIMEOUT_CYCLES-1, complete with ERROR and read_data=0, then go to DONE.
  - DONE: write read_data and response to the winner's outputs, clear its slot valid, raise its *_ready, then go to IDLE.
- Winner selection when both slots are valid: see Configuration. When only one slot is valid, that slot wins.
- The losing requester's slot is held untouched and is served on the next IDLE.
- The non-winning requester's outputs never change during another's transaction.
- bus_ready=1 arriving in IDLE with nothing in flight (late slave after a timeout) is ignored.
- Reset mid-transaction: immediately go to IDLE and clear all slots. bus_start drops asynchronously. The in-flight transaction is abandoned with no response.
- Reset values: bus_start=0, bus_address=0, bus_write=0, bus_write_data=0, if_ready=ls_ready=1, *_response=0, *_read_data=0.

## Timing
- Request sampled at edge N. At N+1, *_ready=0 and the FSM is in IDLE evaluating. bus_start=1 in cycle N+2 (ISSUE), SETTLE in N+3, WAIT from N+4.
- If bus_ready is first seen high in WAIT at edge M: DONE in cycle M+1, and *_ready=1 with data valid from edge M+2.
- Minimum request-to-ready latency: 5 cycles plus slave wait.
- Back-to-back: the second winner's ISSUE is no earlier than 2 cycles after the first's DONE.
- A requester may re-start in the same cycle its *_ready returns high.
- Timeout: ERROR completion exactly TIMEOUT_CYCLES WAIT cycles after entering WAIT.

## Configuration
- BUS_ARB_ROUND_ROBIN_EN defined: a 1-bit last-granted register, reset to "fetch". On contention the requester not granted last wins. The register updates at each ISSUE.
- BUS_ARB_ROUND_ROBIN_EN undefined: fixed priority, load/store always beats fetch on contention. No last-granted register exists.

## Test plan
- Single fetch: if_start, address 0x100; slave returns 0xDEADBEEF OKAY after 3 wait cycles. Expect bus_start exactly one pulse with bus_address=0x100, then if_read_data=0xDEADBEEF, if_response=0, and if_ready high 2 edges after slave completion.
- Contention: both starts in the same cycle, fetch at 0x0, store of 0x12345678 to 0x40. Expect order ls then if in fixed mode, and order ls then if in RR mode from reset (last = fetch). A second simultaneous pair in RR mode expects if first.
- Start while busy: pulse if_start again while if_ready=0 with a different address. Expect no extra bus_start and the original address used.
- Timeout: with TIMEOUT_CYCLES=4, the slave never raises bus_ready. Expect ls_response=1 and ls_read_data=0 after 4 WAIT cycles. A late bus_ready is then ignored.
- Slave error: bus_response=2. Expect the requester sees response=1.
- Reset in WAIT: deassert reset for 1 cycle mid-transaction. Expect bus_start=0, both *_ready=1, outputs zero, no completion afterward.
